// File: rtl/ballot_session_ctrl.sv
// ballot_session_ctrl: one voter session for the 4-candidate voting machine.
// The officer arms a ballot and one candidate press is accepted and tallied.
// Further presses are then locked out for a hold time and until every button
// has been released.
module ballot_session_ctrl #(
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned HOLD_CYC = 10,
   parameter int unsigned TMO_CYC  = 1000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mode,
   input  logic             ballot_en,
   input  logic             clr_counts,
   input  logic             candidate1,
   input  logic             candidate2,
   input  logic             candidate3,
   input  logic             candidate4,
   output logic             any_valid_vote,
   output logic [3:0]       vote_sel,
   output logic             ballot_ready,
   output logic             busy,
   output logic             timeout_pulse,
   output logic             multi_err,
   output logic [CNT_W-1:0] recev_can1,
   output logic [CNT_W-1:0] recev_can2,
   output logic [CNT_W-1:0] recev_can3,
   output logic [CNT_W-1:0] recev_can4
);

   localparam int unsigned TMR_W  = $clog2(TMO_CYC);
   localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TMO_CYC - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ARMED    = 3'd1,
      RECORD   = 3'd2,
      LOCKOUT  = 3'd3,
      WAIT_REL = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [3:0]        sel_d;
   logic              multi_d;
   logic              tmo_d;
   logic              clr_hit;
   logic [3:0]        buttons;
   logic              single_press;
   logic              multi_press;
   logic [CNT_W-1:0]  tally [4];

   assign buttons = {candidate4, candidate3, candidate2, candidate1};
   // A nonzero vector with a bit left after clearing its lowest set bit has two or more bits.
   assign multi_press  = (buttons & (buttons - 4'd1)) != 4'd0;
   assign single_press = (buttons != 4'd0) && !multi_press;

   assign recev_can1 = tally[0];
   assign recev_can2 = tally[1];
   assign recev_can3 = tally[2];
   assign recev_can4 = tally[3];

   // Next-state, timer and strobe decode for the session sequencer.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      hold_d  = hold_q;
      sel_d   = vote_sel;
      multi_d = 1'b0;
      tmo_d   = 1'b0;
      clr_hit = 1'b0;
      case (state_q)
         IDLE: begin
            if (!mode && ballot_en) begin
               state_d = ARMED;
               tmr_d   = '0;
            end else if (mode && clr_counts) begin
               clr_hit = 1'b1;
            end
         end
         ARMED: begin
            // Timer parks at its last value so a multi-press on the expiry
            // cycle defers the timeout to the next cycle instead of wrapping.
            if (tmr_q != TMR_LAST) begin
               tmr_d = tmr_q + 1'b1;
            end
            if (mode) begin
               state_d = IDLE;
            end else if (single_press) begin
               state_d = RECORD;
               sel_d   = buttons;
            end else if (multi_press) begin
               multi_d = 1'b1;
            end else if (tmr_q == TMR_LAST) begin
               state_d = IDLE;
               tmo_d   = 1'b1;
            end
         end
         RECORD: begin
            state_d = LOCKOUT;
            hold_d  = '0;
         end
         LOCKOUT: begin
            if (hold_q == HOLD_LAST) begin
               state_d = WAIT_REL;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         WAIT_REL: begin
            if (buttons == 4'd0) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, timers and registered outputs (decoded from the next state).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         tmr_q          <= '0;
         hold_q         <= '0;
         vote_sel       <= '0;
         any_valid_vote <= 1'b0;
         ballot_ready   <= 1'b0;
         busy           <= 1'b0;
         timeout_pulse  <= 1'b0;
         multi_err      <= 1'b0;
      end else begin
         state_q        <= state_d;
         tmr_q          <= tmr_d;
         hold_q         <= hold_d;
         vote_sel       <= sel_d;
         any_valid_vote <= (state_d == RECORD);
         ballot_ready   <= (state_d == ARMED);
         busy           <= (state_d == RECORD) || (state_d == LOCKOUT) ||
                           (state_d == WAIT_REL);
         timeout_pulse  <= tmo_d;
         multi_err      <= multi_d;
      end
   end

   // Tally counters: cleared on request, saturating increment at the end of RECORD.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < 4; i++) begin
            tally[i] <= '0;
         end
      end else if (clr_hit) begin
         for (int unsigned i = 0; i < 4; i++) begin
            tally[i] <= '0;
         end
      end else if (state_q == RECORD) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (vote_sel[i] && (tally[i] != '1)) begin
               tally[i] <= tally[i] + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ballot_session_ctrl.sv
// Scoreboard bench for ballot_session_ctrl: stimulus pushes expected strobes,
// a monitor pops and compares them whenever the DUT emits a strobe.
module tb_ballot_session_ctrl;

   localparam int unsigned CNT_W    = 8;
   localparam int unsigned HOLD_CYC = 10;
   localparam int unsigned TMO_CYC  = 16;

   logic             clk;
   logic             reset;
   logic             mode;
   logic             ballot_en;
   logic             clr_counts;
   logic             candidate1, candidate2, candidate3, candidate4;
   logic             any_valid_vote;
   logic [3:0]       vote_sel;
   logic             ballot_ready;
   logic             busy;
   logic             timeout_pulse;
   logic             multi_err;
   logic [CNT_W-1:0] recev_can1, recev_can2, recev_can3, recev_can4;

   ballot_session_ctrl #(
      .CNT_W   (CNT_W),
      .HOLD_CYC(HOLD_CYC),
      .TMO_CYC (TMO_CYC)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .mode          (mode),
      .ballot_en     (ballot_en),
      .clr_counts    (clr_counts),
      .candidate1    (candidate1),
      .candidate2    (candidate2),
      .candidate3    (candidate3),
      .candidate4    (candidate4),
      .any_valid_vote(any_valid_vote),
      .vote_sel      (vote_sel),
      .ballot_ready  (ballot_ready),
      .busy          (busy),
      .timeout_pulse (timeout_pulse),
      .multi_err     (multi_err),
      .recev_can1    (recev_can1),
      .recev_can2    (recev_can2),
      .recev_can3    (recev_can3),
      .recev_can4    (recev_can4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // kind one-hot: bit0 vote, bit1 multi_err, bit2 timeout
   typedef struct {
      logic [2:0] kind;
      logic [3:0] sel;
      int         tally;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   model[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic int tally_of(input logic [3:0] sel);
      case (sel)
         4'b0001: return int'(recev_can1);
         4'b0010: return int'(recev_can2);
         4'b0100: return int'(recev_can3);
         4'b1000: return int'(recev_can4);
         default: return -1;
      endcase
   endfunction

   // Monitor: compare every strobe against the head of the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset && (any_valid_vote || multi_err || timeout_pulse)) begin
            if (q.size() == 0) begin
               check("unexpected_strobe", {29'd0, timeout_pulse, multi_err, any_valid_vote}, 0);
            end else begin
               e = q.pop_front();
               check("strobe_kind", {29'd0, timeout_pulse, multi_err, any_valid_vote}, {29'd0, e.kind});
               if (e.kind == 3'b001) begin
                  check("vote_sel", {28'd0, vote_sel}, {28'd0, e.sel});
                  @(posedge clk);
                  @(negedge clk);
                  check("tally_after_vote", tally_of(e.sel), e.tally);
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_btn(input int c, input logic v);
      case (c)
         0: candidate1 = v;
         1: candidate2 = v;
         2: candidate3 = v;
         default: candidate4 = v;
      endcase
   endtask

   task automatic arm();
      ballot_en = 1'b1;
      tick(1);
      ballot_en = 1'b0;
   endtask

   task automatic push_vote(input int c);
      exp_t e;
      if (model[c] != 255) model[c]++;
      e.kind  = 3'b001;
      e.sel   = 4'(1 << c);
      e.tally = model[c];
      q.push_back(e);
   endtask

   task automatic push_kind(input logic [2:0] k);
      exp_t e;
      e.kind  = k;
      e.sel   = 4'd0;
      e.tally = 0;
      q.push_back(e);
   endtask

   // Full session with a one-cycle press; returns to IDLE at the end.
   task automatic session(input int c);
      arm();
      push_vote(c);
      set_btn(c, 1'b1);
      tick(1);
      set_btn(c, 1'b0);
      tick(HOLD_CYC + 3);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) model[i] = 0;
   endtask

   initial begin
      int cnt;
      reset = 1'b0; mode = 1'b0; ballot_en = 1'b0; clr_counts = 1'b0;
      candidate1 = 1'b0; candidate2 = 1'b0; candidate3 = 1'b0; candidate4 = 1'b0;
      for (int i = 0; i < 4; i++) model[i] = 0;
      #1;
      check("reset_ready", ballot_ready, 0);
      check("reset_busy", busy, 0);
      check("reset_sel", vote_sel, 0);
      check("reset_can1", recev_can1, 0);
      tick(2);
      reset = 1'b1;
      tick(2);

      // 1: candidate2 held 3 cycles -> single vote, busy lasts RECORD+LOCKOUT+1
      arm();
      check("t1_ready", ballot_ready, 1);
      push_vote(1);
      candidate2 = 1'b1;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (i == 3) candidate2 = 1'b0;
         @(negedge clk);
         if (busy) cnt++;
         tick(1);
      end
      check("t1_busy_cycles", cnt, HOLD_CYC + 2);
      check("t1_can1", recev_can1, 0);
      check("t1_can2", recev_can2, 1);
      check("t1_can3", recev_can3, 0);
      check("t1_can4", recev_can4, 0);

      // 2: two buttons -> multi_err, stay armed, then a clean press
      arm();
      push_kind(3'b010);
      candidate1 = 1'b1; candidate3 = 1'b1;
      tick(1);
      candidate1 = 1'b0; candidate3 = 1'b0;
      check("t2_still_ready", ballot_ready, 1);
      check("t2_can1", recev_can1, 0);
      tick(1);
      push_vote(2);
      candidate3 = 1'b1;
      tick(1);
      candidate3 = 1'b0;
      tick(HOLD_CYC + 3);
      check("t2_can3", recev_can3, 1);
      check("t2_can1_after", recev_can1, 0);

      // 3: no press -> timeout after exactly TMO_CYC armed cycles
      arm();
      push_kind(3'b100);
      cnt = 0;
      for (int i = 0; i < TMO_CYC + 10; i++) begin
         @(negedge clk);
         if (ballot_ready) cnt++;
         tick(1);
      end
      check("t3_ready_cycles", cnt, TMO_CYC);
      check("t3_ready_low", ballot_ready, 0);
      check("t3_can2", recev_can2, 1);
      check("t3_can3", recev_can3, 1);

      // mode abort while armed: no strobe, back to idle
      arm();
      mode = 1'b1;
      tick(1);
      mode = 1'b0;
      check("abort_ready", ballot_ready, 0);
      check("abort_busy", busy, 0);

      // 4: hold candidate4 through lockout, re-arm while busy is ignored
      arm();
      push_vote(3);
      candidate4 = 1'b1;
      tick(2);
      ballot_en = 1'b1;
      tick(HOLD_CYC + 5);
      check("t4_ready_while_busy", ballot_ready, 0);
      check("t4_busy_held", busy, 1);
      ballot_en = 1'b0;
      candidate4 = 1'b0;
      tick(2);
      check("t4_busy_released", busy, 0);
      check("t4_ready_after", ballot_ready, 0);
      check("t4_can4", recev_can4, 1);

      // 5: drive candidate1 to 255, then one more vote saturates
      for (int i = 0; i < 255; i++) session(0);
      check("t5_can1_255", recev_can1, 255);
      session(0);
      check("t5_can1_sat", recev_can1, 255);

      // 6a: reset mid-ARMED clears everything asynchronously
      arm();
      #2;
      do_reset();
      #1;
      check("t6_armed_ready", ballot_ready, 0);
      check("t6_armed_can1", recev_can1, 0);
      check("t6_armed_sel", vote_sel, 0);
      tick(1);
      reset = 1'b1;
      tick(1);

      // 6b: reset mid-LOCKOUT
      arm();
      push_vote(1);
      candidate2 = 1'b1;
      tick(4);
      candidate2 = 1'b0;
      #2;
      do_reset();
      #1;
      check("t6_lock_busy", busy, 0);
      check("t6_lock_sel", vote_sel, 0);
      check("t6_lock_can2", recev_can2, 0);
      tick(1);
      reset = 1'b1;
      tick(1);

      // 6c: clear honoured only with mode=1 in IDLE; ballot_en ignored in mode=1
      session(2);
      clr_counts = 1'b1;
      tick(1);
      clr_counts = 1'b0;
      check("t6_clr_ignored", recev_can3, 1);
      mode = 1'b1;
      ballot_en = 1'b1;
      tick(1);
      ballot_en = 1'b0;
      check("t6_arm_in_display", ballot_ready, 0);
      clr_counts = 1'b1;
      tick(1);
      clr_counts = 1'b0;
      mode = 1'b0;
      check("t6_clr_can3", recev_can3, 0);
      tick(3);

      check("scoreboard_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard bound so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
